// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial shift engine:
//   state_t  : FSM state encoding (S_IDLE, S_SHIFT, S_DONE)
//   clog2    : ceiling log2, never smaller than 1, for sizing counters
//   eff_len  : maps a requested frame length onto the length actually used
// ---------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // A length of zero, or one longer than the shifter, means a full-width frame.
    function automatic int eff_len(input int len_val, input int width);
        if (len_val == 0 || len_val > width) begin
            return width;
        end
        return len_val;
    endfunction

endpackage

// File: rtl/bit_period_gen.sv
// ---------------------------------------------------------------------------
// bit_period_gen
// Divides CLKB into bit periods of DIV cycles and produces the bit clock.
// Ports:
//   CLKB     in   system clock
//   RSTN     in   asynchronous active-low reset
//   clr      in   holds the divider at phase 0 with sclk low
//   sclk     out  registered bit clock, high for the second half of a bit
//   mid_tick out  last cycle before sclk rises (rx sample point)
//   end_tick out  last cycle of the bit period (commit point)
// ---------------------------------------------------------------------------
module bit_period_gen
    import serial_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic CLKB,
    input  logic RSTN,
    input  logic clr,
    output logic sclk,
    output logic mid_tick,
    output logic end_tick
);

    localparam int DIV_W = clog2(DIV);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;

    assign end_tick = (div == DIV_W'(DIV - 1));
    assign mid_tick = (div == DIV_W'(DIV / 2 - 1));
    assign div_next = end_tick ? '0 : div + DIV_W'(1);

    // sclk is derived from the next divider phase so that the registered
    // output lines up with the current phase: high exactly while div >= DIV/2.
    always_ff @(posedge CLKB or negedge RSTN) begin
        if (!RSTN) begin
            div  <= '0;
            sclk <= 1'b0;
        end else if (clr) begin
            div  <= '0;
            sclk <= 1'b0;
        end else begin
            div  <= div_next;
            sclk <= (div_next >= DIV_W'(DIV / 2));
        end
    end

endmodule

// File: rtl/serial_shift_engine.sv
// ---------------------------------------------------------------------------
// serial_shift_engine
// Full-duplex serial transceiver with runtime frame length and selectable
// bit order. A frame of len bits is shifted out on tx while rx is captured;
// at the end a one-cycle done pulse presents the right-justified rx word.
// Ports:
//   CLKB      in   system clock
//   RSTN      in   asynchronous active-low reset
//   trig      in   start request, accepted while ready is high
//   abort     in   synchronous abort back to idle, no done
//   len       in   frame length (0 or > WIDTH means WIDTH)
//   data_in   in   transmit word, bits [len-1:0] are sent
//   rx        in   serial input
//   tx        out  serial output, idles high
//   sclk      out  registered bit clock
//   ready     out  engine can accept trig
//   done      out  one-cycle end-of-frame strobe
//   data_out  out  received word, valid from the done cycle onward
// ---------------------------------------------------------------------------
module serial_shift_engine
    import serial_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LEN_W     = 6,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLKB,
    input  logic             RSTN,
    input  logic             trig,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rx,
    output logic             tx,
    output logic             sclk,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    state_t           state;
    state_t           next_state;

    logic             load;
    logic             commit;
    logic             last_bit;
    logic             clr;
    logic             mid_tick;
    logic             end_tick;
    logic             rx_bit;
    logic             tx_bit;

    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] rx_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] bitcnt;
    logic [LEN_W-1:0] tx_idx;

    assign len_eff  = LEN_W'(eff_len(int'(len), WIDTH));
    assign last_bit = (bitcnt == len_reg - LEN_W'(1));

    // The divider only runs while shifting; abort clears it the same cycle
    // so the engine lands in idle with sclk already low.
    assign clr = (state != S_SHIFT) || abort;

    bit_period_gen #(
        .DIV (DIV)
    ) u_bit_period_gen (
        .CLKB     (CLKB),
        .RSTN     (RSTN),
        .clr      (clr),
        .sclk     (sclk),
        .mid_tick (mid_tick),
        .end_tick (end_tick)
    );

    always_ff @(posedge CLKB or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort outranks both the end-of-frame transition and a new trig.
    // DONE accepts trig directly so frames can run back to back.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig && !abort) begin
                    load       = 1'b1;
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (end_tick) begin
                    commit = 1'b1;
                    if (last_bit) begin
                        next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (trig && !abort) begin
                    load       = 1'b1;
                    next_state = S_SHIFT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Bit selection is done by comparison rather than a variable part-select
    // so the index width never has to match the word width.
    always_comb begin
        if (MSB_FIRST != 0) begin
            tx_idx = len_reg - LEN_W'(1) - bitcnt;
        end else begin
            tx_idx = bitcnt;
        end
        tx_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LEN_W'(i) == tx_idx) begin
                tx_bit = tx_reg[i];
            end
        end
    end

    // MSB-first frames build up by shifting left, so a short frame ends up
    // right-justified without any final realignment. LSB-first frames write
    // each bit straight into its own position.
    always_comb begin
        rx_next = rx_reg;
        if (MSB_FIRST != 0) begin
            rx_next    = rx_reg << 1;
            rx_next[0] = rx_bit;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (LEN_W'(i) == bitcnt) begin
                    rx_next[i] = rx_bit;
                end
            end
        end
    end

    // Frame datapath. data_out is loaded on the final commit so it is already
    // valid during the done cycle, and is left untouched by an abort.
    always_ff @(posedge CLKB or negedge RSTN) begin
        if (!RSTN) begin
            tx_reg   <= '0;
            rx_reg   <= '0;
            len_reg  <= '0;
            bitcnt   <= '0;
            rx_bit   <= 1'b0;
            data_out <= '0;
        end else begin
            if (load) begin
                tx_reg  <= data_in;
                len_reg <= len_eff;
                rx_reg  <= '0;
                bitcnt  <= '0;
            end else if (commit) begin
                rx_reg <= rx_next;
                bitcnt <= bitcnt + LEN_W'(1);
                if (last_bit) begin
                    data_out <= rx_next;
                end
            end
            if (state == S_SHIFT && mid_tick) begin
                rx_bit <= rx;
            end
        end
    end

    assign tx    = (state == S_SHIFT) ? tx_bit : 1'b1;
    assign ready = (state != S_SHIFT);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_serial_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_engine
// Two engines (MSB-first and LSB-first) share trig/len/data_in/abort/reset.
// The LSB-first engine is always in loopback; the MSB-first engine can take
// rx from a driven sequence instead. Expected tx bits and done results are
// queued when a frame is issued and popped by independent monitors.
// ---------------------------------------------------------------------------
module tb_serial_shift_engine;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int DIV   = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cycle;
    } done_item_t;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             trig     = 1'b0;
    logic             abort    = 1'b0;
    logic             rx_drive = 1'b1;
    logic             loop_msb = 1'b1;
    logic [LEN_W-1:0] len      = '0;
    logic [WIDTH-1:0] data_in  = '0;

    logic             rx_msb, tx_msb, sclk_msb, ready_msb, done_msb;
    logic             rx_lsb, tx_lsb, sclk_lsb, ready_lsb, done_lsb;
    logic [WIDTH-1:0] data_out_msb, data_out_lsb;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    done_item_t done_q_msb[$];
    done_item_t done_q_lsb[$];
    logic       tx_q_msb[$];
    logic       tx_q_lsb[$];

    assign rx_msb = loop_msb ? tx_msb : rx_drive;
    assign rx_lsb = tx_lsb;

    serial_shift_engine #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .DIV(DIV), .MSB_FIRST(1)
    ) dut_msb (
        .CLKB(clk), .RSTN(rst_n), .trig(trig), .abort(abort), .len(len),
        .data_in(data_in), .rx(rx_msb), .tx(tx_msb), .sclk(sclk_msb),
        .ready(ready_msb), .done(done_msb), .data_out(data_out_msb)
    );

    serial_shift_engine #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .DIV(DIV), .MSB_FIRST(0)
    ) dut_lsb (
        .CLKB(clk), .RSTN(rst_n), .trig(trig), .abort(abort), .len(len),
        .data_in(data_in), .rx(rx_lsb), .tx(tx_lsb), .sclk(sclk_lsb),
        .ready(ready_lsb), .done(done_lsb), .data_out(data_out_lsb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_tx_msb"},       tx_msb,       1);
        check_output({tag, "_sclk_msb"},     sclk_msb,     0);
        check_output({tag, "_ready_msb"},    ready_msb,    1);
        check_output({tag, "_done_msb"},     done_msb,     0);
        check_output({tag, "_data_out_msb"}, data_out_msb, 0);
        check_output({tag, "_tx_lsb"},       tx_lsb,       1);
        check_output({tag, "_sclk_lsb"},     sclk_lsb,     0);
        check_output({tag, "_ready_lsb"},    ready_lsb,    1);
        check_output({tag, "_done_lsb"},     done_lsb,     0);
        check_output({tag, "_data_out_lsb"}, data_out_lsb, 0);
    endtask

    // Queue the first count bits of an n-bit send sequence (first bit sent is
    // seq[n-1]) for each engine.
    task automatic push_tx(input int n, input int count,
                           input logic [WIDTH-1:0] seq_msb,
                           input logic [WIDTH-1:0] seq_lsb);
        for (int k = 0; k < count; k++) begin
            tx_q_msb.push_back(seq_msb[n-1-k]);
            tx_q_lsb.push_back(seq_lsb[n-1-k]);
        end
    endtask

    task automatic push_done(input int c0, input int n,
                             input logic [WIDTH-1:0] exp_msb,
                             input logic [WIDTH-1:0] exp_lsb);
        done_item_t item;
        item.cycle = c0 + 1 + n * DIV;
        item.data  = exp_msb;
        done_q_msb.push_back(item);
        item.data  = exp_lsb;
        done_q_lsb.push_back(item);
    endtask

    // Issue one complete frame from the current cycle and run it to the end.
    // rx_seq drives the MSB-first engine's rx when loopback is off.
    task automatic apply_stimulus(input logic [WIDTH-1:0] data,
                                  input logic [LEN_W-1:0] len_val, input int n,
                                  input logic [WIDTH-1:0] seq_msb,
                                  input logic [WIDTH-1:0] seq_lsb,
                                  input logic [WIDTH-1:0] exp_msb,
                                  input logic [WIDTH-1:0] exp_lsb,
                                  input logic [WIDTH-1:0] rx_seq);
        trig    = 1'b1;
        data_in = data;
        len     = len_val;
        push_tx(n, n, seq_msb, seq_lsb);
        push_done(cyc, n, exp_msb, exp_lsb);
        @(posedge clk); #1;
        trig = 1'b0;
        for (int k = 0; k < n; k++) begin
            rx_drive = rx_seq[n-1-k];
            repeat (DIV) @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        rx_drive = 1'b1;
    endtask

    // Done monitors: every done pulse must match the next queued frame result.
    always @(negedge clk) begin
        done_item_t item;
        if (done_msb === 1'b1) begin
            if (done_q_msb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL msb_unexpected_done: done=1 in cycle %0d, required 0", cyc);
            end else begin
                item = done_q_msb.pop_front();
                check_output("msb_data_out", data_out_msb, item.data);
                check_output("msb_done_cycle", cyc, item.cycle);
            end
        end
        if (done_lsb === 1'b1) begin
            if (done_q_lsb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL lsb_unexpected_done: done=1 in cycle %0d, required 0", cyc);
            end else begin
                item = done_q_lsb.pop_front();
                check_output("lsb_data_out", data_out_lsb, item.data);
                check_output("lsb_done_cycle", cyc, item.cycle);
            end
        end
    end

    // tx monitors: tx is sampled on each sclk rise, mid bit period.
    always @(posedge sclk_msb) begin
        #1;
        if (tx_q_msb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL msb_extra_sclk: sclk pulse in cycle %0d, none required", cyc);
        end else begin
            check_output("msb_tx_bit", tx_msb, tx_q_msb.pop_front());
        end
    end

    always @(posedge sclk_lsb) begin
        #1;
        if (tx_q_lsb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL lsb_extra_sclk: sclk pulse in cycle %0d, none required", cyc);
        end else begin
            check_output("lsb_tx_bit", tx_lsb, tx_q_lsb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        $display("[TB] serial_shift_engine test starting");

        #2;
        check_reset("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset("after_reset");
        @(posedge clk); #1;

        // Loopback, 0xA5, full length.
        apply_stimulus(8'hA5, 4'd8, 8, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00);

        // len=4, MSB-first engine receives 1,0,0,1 from the bench.
        loop_msb = 1'b0;
        apply_stimulus(8'hFC, 4'd4, 4, 8'h0C, 8'h03, 8'h09, 8'h0C, 8'h09);
        loop_msb = 1'b1;

        // 0x3C full length, then len=0 and len=9 both mean full width.
        apply_stimulus(8'h3C, 4'd8, 8, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00);
        apply_stimulus(8'h3C, 4'd0, 8, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00);
        apply_stimulus(8'h01, 4'd9, 8, 8'h01, 8'h80, 8'h01, 8'h01, 8'h00);

        // Busy trig ignored, then trig held in the done cycle chains a frame.
        c0      = cyc;
        trig    = 1'b1;
        data_in = 8'h96;
        len     = 4'd8;
        push_tx(8, 8, 8'h96, 8'h69);
        push_done(c0, 8, 8'h96, 8'h96);
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (9) @(posedge clk); #1;
        check_output("busy_ready_msb", ready_msb, 0);
        check_output("busy_ready_lsb", ready_lsb, 0);
        trig    = 1'b1;
        data_in = 8'hFF;
        len     = 4'd2;
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (22) @(posedge clk); #1;
        check_output("done_cycle_ready_msb", ready_msb, 1);
        check_output("done_cycle_ready_lsb", ready_lsb, 1);
        trig    = 1'b1;
        data_in = 8'h06;
        len     = 4'd3;
        push_tx(3, 3, 8'h06, 8'h03);
        push_done(cyc, 3, 8'h06, 8'h06);
        @(posedge clk); #1;
        trig = 1'b0;
        check_output("chained_ready_msb", ready_msb, 0);
        check_output("chained_ready_lsb", ready_lsb, 0);
        repeat (14) @(posedge clk); #1;

        // Abort during the third bit: three sclk pulses, no done.
        trig    = 1'b1;
        data_in = 8'hF0;
        len     = 4'd8;
        push_tx(8, 3, 8'hF0, 8'h0F);
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (11) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_output("abort_tx_msb",    tx_msb,    1);
        check_output("abort_sclk_msb",  sclk_msb,  0);
        check_output("abort_ready_msb", ready_msb, 1);
        check_output("abort_tx_lsb",    tx_lsb,    1);
        check_output("abort_sclk_lsb",  sclk_lsb,  0);
        check_output("abort_ready_lsb", ready_lsb, 1);
        repeat (20) @(posedge clk); #1;
        check_output("abort_data_out_msb", data_out_msb, 8'h06);
        check_output("abort_data_out_lsb", data_out_lsb, 8'h06);

        // Reset pulse mid-frame after two bits, then a clean frame.
        trig    = 1'b1;
        data_in = 8'hC3;
        len     = 4'd8;
        push_tx(8, 2, 8'hC3, 8'hC3);
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (9) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_frame_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(8'h4B, 4'd8, 8, 8'h4B, 8'hD2, 8'h4B, 8'h4B, 8'h00);

        repeat (4) @(posedge clk); #1;
        check_output("leftover_done_msb", done_q_msb.size(), 0);
        check_output("leftover_done_lsb", done_q_lsb.size(), 0);
        check_output("leftover_tx_msb",   tx_q_msb.size(),   0);
        check_output("leftover_tx_lsb",   tx_q_lsb.size(),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
